l1_miss_req: RTL and testbench
==============================

Name: l1_miss_req

Overview:
- Requester-side miss/writeback buffer for an L1 cache (icache or dcache instance).
- Accepts line-miss and eviction requests from the cache and issues them as t_mem_req_pkt to the L2 port.
- Tracks outstanding reads by id and matches returning t_mem_rsp_pkt to deliver fill data back to the cache.
- One instance per L2 port (dc, ic); it drives the req side the L2 samples and consumes the rsp side the L2 drives.

Parameters:
- NUM_ENTRIES, 4, number of miss-buffer entries; must be <= 2^(width of t_mem_req_pkt.id).
- ID_BASE, 0, constant added to the entry index to form the request id, keeping ids unique when ports share a tracker.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  cache presents a request this cycle
- alloc_op  in  t_mem_op  MEM_OP_READ, MEM_OP_READ_INV or MEM_OP_WRITE
- alloc_addr  in  t_paddr  byte address; low log2(CL_SZ_BYTES) bits ignored
- alloc_data  in  t_cl  line data, used for MEM_OP_WRITE only
- alloc_ready  out  1  request accepted when alloc_valid & alloc_ready
- req_pkt  out  t_mem_req_pkt  request to L2 (valid, id, op, addr, data)
- rsp_pkt  in  t_mem_rsp_pkt  response from L2 (valid, id, data)
- fill_valid  out  1  fill data returned this cycle
- fill_addr  out  t_paddr  line-aligned address of the fill
- fill_data  out  t_cl  fill line data
- idle  out  1  no entry allocated

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Entry state is t_mrq_state, one of:
  - IDLE: entry free.
  - PEND: allocated, not yet issued.
  - WAIT: read issued, awaiting response.
- Each entry stores op, line-aligned addr and data.
- Allocation:
  - A request accepted in cycle N writes the lowest-index IDLE entry at the end of N; that entry is PEND in N+1.
  - alloc_ready is computed from current state only. An entry freed in cycle N is not usable by an allocation in cycle N.
- Merge: a read to a line already held as a PEND or WAIT read is accepted without a new entry. The cache receives a single fill.
- Hazard stall:
  - alloc_ready=0 for a read when the same line has a PEND write.
  - alloc_ready=0 for a write when the same line has a PEND or WAIT read.
  - alloc_ready=0 when no IDLE entry exists and the request is not a merge.
- Issue:
  - Each cycle the lowest-index PEND entry is selected. req_pkt is driven from the flopped entry fields: valid=1, id=ID_BASE+index, op, addr; data is the entry data for writes and '0 for reads.
  - At most one request per cycle. The L2 has no backpressure, so every issued request is taken.
  - Latency: allocation in cycle N gives req_pkt.valid in N+1 at the earliest.
- Entry transitions at issue:
  - Read entries move PEND->WAIT.
  - Write entries move PEND->IDLE (no response exists for writes).
- No PEND entry: req_pkt='0.
- Response: rsp_pkt.valid with rsp_pkt.id matching a WAIT entry drives fill_valid=1, fill_addr=entry addr, fill_data=rsp_pkt.data combinationally in the same cycle. The entry goes to IDLE at the end of that cycle. The L2 answers the cycle after issue, so allocation-to-fill latency is a minimum of 2 cycles.
- Unmatched response (no WAIT entry with that id): ignored, fill_valid=0. An assertion fires under ASSERT.
- Simultaneous events in one cycle must all complete correctly: issue of entry A, response for entry B, and allocation into entry C.
- idle=1 iff all entries are IDLE.
- Reset values:
  - All entries IDLE.
  - req_pkt='0, fill_valid=0, fill_addr='0, fill_data='0.
  - alloc_ready=1, idle=1.
- Reset mid-operation: outstanding reads are dropped. Responses arriving after reset are unmatched and ignored.

Decomposition:
- The mem_defs package gets t_mrq_state, t_mrq_entry (state, op, addr, data) and the line-offset width constant derived from CL_SZ_BYTES.
- Lowest-index select is reused for both allocation and issue; take it from gen_funcs as a function, not a new module.
- Natural sub-module: l1_miss_req_entry, which holds one entry's state machine and fields, plus address-match outputs for the merge and hazard checks.

Test Plan:
- Single read: alloc READ addr 0x1234 in cycle 0 -> req_pkt valid cycle 1 with addr 0x1200 (CL_SZ_BYTES=64) and id 0. L2 model rsp cycle 2 -> fill_valid cycle 2, fill_addr 0x1200; idle=1 in cycle 3.
- Fill: 4 reads to 0x000, 0x040, 0x080, 0x0C0 in back-to-back cycles -> ids 0..3 issued in order. A 5th alloc is stalled (alloc_ready=0) until the first fill frees an entry.
- Write: alloc WRITE 0x2000 with data pattern 0xA5 -> req op WRITE with that data. Entry is freed the cycle after issue; no fill is produced. A following read of 0x2000 through the L2 model returns 0xA5 bytes.
- Merge and hazard:
  - Two reads to 0x3000 in consecutive cycles -> one request, one fill.
  - A write to 0x3000 while that read is in WAIT -> alloc_ready=0 until the fill arrives.
- Simultaneity and bad id:
  - In the same cycle, a response for id 1, issue of id 2, and a new alloc -> all three take effect.
  - An injected rsp with an id that has no WAIT entry -> no fill and the assertion fires.
- Reset: assert reset with 2 reads in WAIT -> next cycle idle=1 and req_pkt='0. The late rsp for the old id is ignored.

Source files
------------

// File: rtl/l1_miss_req_pkg.sv
// Shared memory-port types, miss-buffer entry types and small helper functions
// for the L1 miss/writeback request buffer.
package l1_miss_req_pkg;

  localparam int unsigned CL_SZ_BYTES = 64;
  localparam int unsigned CL_W        = CL_SZ_BYTES * 8;
  localparam int unsigned CL_OFF_W    = $clog2(CL_SZ_BYTES);
  localparam int unsigned PADDR_W     = 32;
  localparam int unsigned MEM_ID_W    = 4;
  localparam int unsigned MAX_ENTRIES = 1 << MEM_ID_W;

  typedef logic [PADDR_W-1:0]  t_paddr;
  typedef logic [CL_W-1:0]     t_cl;
  typedef logic [MEM_ID_W-1:0] t_mem_id;

  typedef enum logic [1:0] {
    MEM_OP_READ     = 2'd0,
    MEM_OP_READ_INV = 2'd1,
    MEM_OP_WRITE    = 2'd2
  } t_mem_op;

  typedef struct packed {
    logic    valid;
    t_mem_id id;
    t_mem_op op;
    t_paddr  addr;
    t_cl     data;
  } t_mem_req_pkt;

  typedef struct packed {
    logic    valid;
    t_mem_id id;
    t_cl     data;
  } t_mem_rsp_pkt;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    WAIT
  } t_mrq_state;

  typedef struct packed {
    t_mrq_state state;
    t_mem_op    op;
    t_paddr     addr;
    t_cl        data;
  } t_mrq_entry;

  // Index of the lowest set bit; callers qualify the result with |vec.
  function automatic t_mem_id lowest_set(input logic [MAX_ENTRIES-1:0] vec);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < MAX_ENTRIES; i++) begin
      if (vec[i] && !found) begin
        found      = 1'b1;
        lowest_set = t_mem_id'(i);
      end
    end
  endfunction

  function automatic t_paddr line_align(input t_paddr a);
    return {a[PADDR_W-1:CL_OFF_W], {CL_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/l1_miss_req_entry.sv
// One miss-buffer entry: IDLE/PEND/WAIT state machine, stored request fields
// and line-address match outputs used for merge and hazard detection.
module l1_miss_req_entry
  import l1_miss_req_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       alloc_i,
  input  t_mem_op    alloc_op_i,
  input  t_paddr     alloc_addr_i,
  input  t_cl        alloc_data_i,
  input  logic       issue_i,
  input  logic       rsp_hit_i,
  input  t_paddr     cmp_addr_i,
  output t_mrq_entry entry_o,
  output logic       rd_match_o,
  output logic       wr_pend_match_o
);

  t_mrq_state state_q, state_d;
  t_mem_op    op_q;
  t_paddr     addr_q;
  t_cl        data_q;
  logic       same_line, is_wr;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (alloc_i) begin
      op_q   <= alloc_op_i;
      addr_q <= alloc_addr_i;
      data_q <= alloc_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (alloc_i)   state_d = PEND;
      // Writes have no response, so they retire at issue.
      PEND:    if (issue_i)   state_d = is_wr ? IDLE : WAIT;
      WAIT:    if (rsp_hit_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    same_line       = (addr_q == cmp_addr_i);
    is_wr           = (op_q == MEM_OP_WRITE);
    rd_match_o      = (state_q != IDLE) && !is_wr && same_line;
    wr_pend_match_o = (state_q == PEND) && is_wr && same_line;
    entry_o.state   = state_q;
    entry_o.op      = op_q;
    entry_o.addr    = addr_q;
    entry_o.data    = data_q;
  end

endmodule

// File: rtl/l1_miss_req.sv
// L1 miss/writeback request buffer: allocates cache requests into entries,
// issues them to the L2 port and matches read responses back into line fills.
module l1_miss_req
  import l1_miss_req_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned ID_BASE     = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         alloc_valid,
  input  t_mem_op      alloc_op,
  input  t_paddr       alloc_addr,
  input  t_cl          alloc_data,
  output logic         alloc_ready,
  output t_mem_req_pkt req_pkt,
  input  t_mem_rsp_pkt rsp_pkt,
  output logic         fill_valid,
  output t_paddr       fill_addr,
  output t_cl          fill_data,
  output logic         idle
);

  t_mrq_entry             ent [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] rd_match, wr_pend_match, ent_alloc, ent_issue, ent_hit;
  logic [MAX_ENTRIES-1:0] free_vec, pend_vec;
  t_mem_id                alloc_idx, issue_idx;
  t_paddr                 alloc_line;
  logic                   alloc_is_rd, merge, do_alloc;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
    l1_miss_req_entry u_entry (
      .clk             (clk),
      .reset           (reset),
      .alloc_i         (ent_alloc[g]),
      .alloc_op_i      (alloc_op),
      .alloc_addr_i    (alloc_line),
      .alloc_data_i    (alloc_data),
      .issue_i         (ent_issue[g]),
      .rsp_hit_i       (ent_hit[g]),
      .cmp_addr_i      (alloc_line),
      .entry_o         (ent[g]),
      .rd_match_o      (rd_match[g]),
      .wr_pend_match_o (wr_pend_match[g])
    );
  end

  always_comb begin
    alloc_line  = line_align(alloc_addr);
    alloc_is_rd = (alloc_op != MEM_OP_WRITE);
    free_vec    = '0;
    pend_vec    = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i] = (ent[i].state == IDLE);
      pend_vec[i] = (ent[i].state == PEND);
    end
    alloc_idx = lowest_set(free_vec);
    issue_idx = lowest_set(pend_vec);
    idle      = (free_vec[NUM_ENTRIES-1:0] == '1);

    // Reads to a line already in flight merge; conflicting read/write pairs stall.
    merge = alloc_is_rd && (|rd_match);
    if (alloc_is_rd) alloc_ready = !(|wr_pend_match) && (merge || (|free_vec));
    else             alloc_ready = !(|rd_match) && (|free_vec);
    do_alloc = alloc_valid && alloc_ready && !merge;
  end

  always_comb begin
    ent_alloc  = '0;
    ent_issue  = '0;
    ent_hit    = '0;
    req_pkt    = '0;
    fill_valid = 1'b0;
    fill_addr  = '0;
    fill_data  = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      ent_alloc[i] = do_alloc && (alloc_idx == t_mem_id'(i));
      if (pend_vec[i] && (issue_idx == t_mem_id'(i))) begin
        ent_issue[i]  = 1'b1;
        req_pkt.valid = 1'b1;
        req_pkt.id    = t_mem_id'(ID_BASE + i);
        req_pkt.op    = ent[i].op;
        req_pkt.addr  = ent[i].addr;
        req_pkt.data  = (ent[i].op == MEM_OP_WRITE) ? ent[i].data : '0;
      end
      if (rsp_pkt.valid && (ent[i].state == WAIT) && (rsp_pkt.id == t_mem_id'(ID_BASE + i))) begin
        ent_hit[i] = 1'b1;
        fill_valid = 1'b1;
        fill_addr  = ent[i].addr;
        fill_data  = rsp_pkt.data;
      end
    end
  end

`ifdef ASSERT
  a_rsp_matched: assert property (@(posedge clk) disable iff (reset) rsp_pkt.valid |-> (|ent_hit));
`endif

endmodule

// File: tb/tb_l1_miss_req.sv
// Bench for l1_miss_req: directed stimulus, an L2 responder model and an
// abstract buffer model compared against the DUT every cycle.
module tb_l1_miss_req;
  import l1_miss_req_pkg::*;

  localparam int unsigned NE  = 4;
  localparam int unsigned IDB = 0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         alloc_valid;
  t_mem_op      alloc_op;
  t_paddr       alloc_addr;
  t_cl          alloc_data;
  logic         alloc_ready;
  t_mem_req_pkt req_pkt;
  t_mem_rsp_pkt rsp_pkt;
  logic         fill_valid;
  t_paddr       fill_addr;
  t_cl          fill_data;
  logic         idle;

  l1_miss_req #(.NUM_ENTRIES(NE), .ID_BASE(IDB)) dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_valid (alloc_valid),
    .alloc_op    (alloc_op),
    .alloc_addr  (alloc_addr),
    .alloc_data  (alloc_data),
    .alloc_ready (alloc_ready),
    .req_pkt     (req_pkt),
    .rsp_pkt     (rsp_pkt),
    .fill_valid  (fill_valid),
    .fill_addr   (fill_addr),
    .fill_data   (fill_data),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [599:0] act, input logic [599:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- L2 model: memory, response queue, logs ----------------
  typedef struct {int unsigned due; t_mem_id id; t_cl data;} rsp_t;
  typedef struct {int unsigned c; t_mem_id id; t_mem_op op; t_paddr addr;} iss_t;
  typedef struct {int unsigned c; t_paddr addr; t_cl data;} fil_t;

  t_cl         mem [t_paddr];
  rsp_t        rq [$];
  iss_t        issue_log [$];
  fil_t        fill_log [$];
  int unsigned dly = 1;
  logic        inj = 1'b0;
  t_mem_id     inj_id = '0;

  function automatic t_cl rd_mem(input t_paddr a);
    if (mem.exists(a)) return mem[a];
    return {16{a}};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (req_pkt.valid) begin
        issue_log.push_back('{cyc, req_pkt.id, req_pkt.op, req_pkt.addr});
        if (req_pkt.op == MEM_OP_WRITE) mem[req_pkt.addr] = req_pkt.data;
        else rq.push_back('{cyc + dly, req_pkt.id, rd_mem(req_pkt.addr)});
      end
      if (fill_valid) fill_log.push_back('{cyc, fill_addr, fill_data});
    end
  end

  initial begin
    rsp_pkt = '0;
    forever begin
      @(posedge clk);
      #1;
      rsp_pkt = '0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        rsp_pkt.valid = 1'b1;
        rsp_pkt.id    = rq[0].id;
        rsp_pkt.data  = rq[0].data;
        void'(rq.pop_front());
      end else if (inj) begin
        rsp_pkt.valid = 1'b1;
        rsp_pkt.id    = inj_id;
        rsp_pkt.data  = '1;
        inj = 1'b0;
      end
    end
  end

  // ---------------- Abstract model of the buffer ----------------
  // Slot status: 0 free, 1 waiting to go out, 2 read out and awaiting data.
  typedef struct {int st; t_mem_op op; t_paddr addr; t_cl data;} slot_t;
  slot_t m [NE];

  initial foreach (m[i]) m[i].st = 0;

  always @(negedge clk) begin
    t_paddr       line;
    bit           rd, merge, haz, eready, eidle;
    int           fi, pi, hi;
    t_mem_req_pkt er;
    if (reset) begin
      foreach (m[i]) m[i].st = 0;
    end else begin
      line  = alloc_addr & ~t_paddr'(CL_SZ_BYTES - 1);
      rd    = (alloc_op != MEM_OP_WRITE);
      merge = 0; haz = 0; eidle = 1;
      fi = -1; pi = -1; hi = -1;
      for (int i = 0; i < NE; i++) begin
        if (m[i].st != 0) eidle = 0;
        if (m[i].st == 0 && fi < 0) fi = i;
        if (m[i].st == 1 && pi < 0) pi = i;
        if (m[i].st == 2 && rsp_pkt.valid && rsp_pkt.id == t_mem_id'(IDB + i)) hi = i;
        if (m[i].st != 0 && m[i].addr == line) begin
          if (m[i].op != MEM_OP_WRITE && rd)  merge = 1;
          if (m[i].op != MEM_OP_WRITE && !rd) haz = 1;
          if (m[i].op == MEM_OP_WRITE && m[i].st == 1 && rd) haz = 1;
        end
      end
      eready = !haz && (merge || fi >= 0);
      er = '0;
      if (pi >= 0) begin
        er.valid = 1'b1;
        er.id    = t_mem_id'(IDB + pi);
        er.op    = m[pi].op;
        er.addr  = m[pi].addr;
        er.data  = (m[pi].op == MEM_OP_WRITE) ? m[pi].data : '0;
      end
      if (alloc_valid) chk("model.alloc_ready", 600'(alloc_ready), 600'(eready));
      chk("model.req_pkt", 600'(req_pkt), 600'(er));
      chk("model.fill_valid", 600'(fill_valid), 600'(hi >= 0));
      if (hi >= 0) begin
        chk("model.fill_addr", 600'(fill_addr), 600'(m[hi].addr));
        chk("model.fill_data", 600'(fill_data), 600'(rsp_pkt.data));
      end
      chk("model.idle", 600'(idle), 600'(eidle));
      if (pi >= 0) m[pi].st = (m[pi].op == MEM_OP_WRITE) ? 0 : 2;
      if (hi >= 0) m[hi].st = 0;
      if (alloc_valid && eready && !merge && fi >= 0) m[fi] = '{1, alloc_op, line, alloc_data};
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noalloc();
    alloc_valid = 1'b0;
    alloc_op    = MEM_OP_READ;
    alloc_addr  = '0;
    alloc_data  = '0;
  endtask

  task automatic alloc(input t_mem_op op, input t_paddr a, input t_cl d,
                       output int unsigned acc, output int unsigned stalls);
    alloc_valid = 1'b1;
    alloc_op    = op;
    alloc_addr  = a;
    alloc_data  = d;
    stalls      = 0;
    acc         = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (alloc_ready) begin
        acc = cyc;
        step();
        return;
      end
      stalls++;
      step();
    end
    timeout("alloc_accept");
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (idle && rq.size() == 0 && !rsp_pkt.valid) begin
        step();
        return;
      end
    end
    timeout("drain");
    step();
  endtask

  function automatic bit has_fill(input int unsigned c, input t_paddr a);
    foreach (fill_log[i]) if (fill_log[i].c == c && fill_log[i].addr == a) return 1;
    return 0;
  endfunction

  function automatic bit has_issue(input int unsigned c, input t_mem_id id, input t_paddr a);
    foreach (issue_log[i])
      if (issue_log[i].c == c && issue_log[i].id == id && issue_log[i].addr == a) return 1;
    return 0;
  endfunction

  function automatic int count_reads(input t_paddr a);
    int n = 0;
    foreach (issue_log[i]) if (issue_log[i].op != MEM_OP_WRITE && issue_log[i].addr == a) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- Directed sequence ----------------
  initial begin
    int unsigned c0, c1, c2, c3, c4, s, s1, s2, s3, s4;
    int unsigned nf;
    t_cl pat;
    noalloc();
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("reset.idle", 600'(idle), 600'(1));
    chk("reset.alloc_ready", 600'(alloc_ready), 600'(1));
    chk("reset.req_pkt", 600'(req_pkt), 600'(0));
    chk("reset.fill_valid", 600'(fill_valid), 600'(0));
    step();

    // Single read: request next cycle, fill the cycle after, then idle.
    dly = 1;
    alloc(MEM_OP_READ, 32'h1234, '0, c0, s);
    noalloc();
    @(negedge clk);
    chk("single.req_valid", 600'(req_pkt.valid), 600'(1));
    chk("single.req_addr", 600'(req_pkt.addr), 600'(32'h1200));
    chk("single.req_id", 600'(req_pkt.id), 600'(0));
    step();
    @(negedge clk);
    chk("single.fill_valid", 600'(fill_valid), 600'(1));
    chk("single.fill_addr", 600'(fill_addr), 600'(32'h1200));
    step();
    @(negedge clk);
    chk("single.idle", 600'(idle), 600'(1));
    step();

    // Fill all entries, fifth request waits for the first fill.
    dly = 6;
    issue_log.delete(); fill_log.delete();
    alloc(MEM_OP_READ, 32'h000, '0, c0, s1);
    alloc(MEM_OP_READ, 32'h040, '0, c1, s2);
    alloc(MEM_OP_READ, 32'h080, '0, c2, s3);
    alloc(MEM_OP_READ, 32'h0C0, '0, c3, s4);
    alloc(MEM_OP_READ, 32'h100, '0, c4, s);
    noalloc();
    chk("full.back_to_back", 600'(c3 - c0), 600'(3));
    chk("full.fifth_stalls", 600'(s), 600'(4));
    chk("full.fifth_accept", 600'(c4), 600'(c0 + 8));
    chk("full.first_fill_cycle", 600'(fill_log.size() > 0 ? fill_log[0].c : 0), 600'(c0 + 7));
    for (int i = 0; i < 4; i++)
      chk("full.issue_order", 600'(issue_log.size() > i ? issue_log[i].id : 4'hF), 600'(i));
    drain();

    // Write: data goes out with the request, no fill, read back returns it.
    dly = 1;
    issue_log.delete(); fill_log.delete();
    pat = {64{8'hA5}};
    alloc(MEM_OP_WRITE, 32'h2000, pat, c0, s);
    noalloc();
    @(negedge clk);
    chk("write.req_op", 600'(req_pkt.op), 600'(MEM_OP_WRITE));
    chk("write.req_addr", 600'(req_pkt.addr), 600'(32'h2000));
    chk("write.req_data", 600'(req_pkt.data), 600'(pat));
    step();
    @(negedge clk);
    chk("write.freed_idle", 600'(idle), 600'(1));
    chk("write.no_fill", 600'(fill_valid), 600'(0));
    step();
    alloc(MEM_OP_READ, 32'h2000, '0, c1, s);
    noalloc();
    drain();
    chk("write.fill_count", 600'(fill_log.size()), 600'(1));
    chk("write.readback", 600'(fill_log.size() > 0 ? fill_log[0].data : '0), 600'(pat));

    // Merge and write-after-read hazard.
    dly = 4;
    issue_log.delete(); fill_log.delete();
    alloc(MEM_OP_READ, 32'h3000, '0, c0, s1);
    alloc(MEM_OP_READ, 32'h3010, '0, c1, s2);
    alloc(MEM_OP_WRITE, 32'h3000, {64{8'h3C}}, c2, s3);
    noalloc();
    chk("merge.no_stall", 600'(s2), 600'(0));
    chk("hazard.stalls", 600'(s3), 600'(4));
    chk("hazard.accept", 600'(c2), 600'(c0 + 6));
    drain();
    chk("merge.one_request", 600'(count_reads(32'h3000)), 600'(1));
    chk("merge.one_fill", 600'(fill_log.size()), 600'(1));

    // Response, issue and allocation all in one cycle.
    dly = 1;
    issue_log.delete(); fill_log.delete();
    alloc(MEM_OP_READ, 32'h4000, '0, c0, s);
    alloc(MEM_OP_READ, 32'h4040, '0, c1, s);
    alloc(MEM_OP_READ, 32'h4080, '0, c2, s);
    alloc(MEM_OP_READ, 32'h40C0, '0, c3, s);
    noalloc();
    drain();
    chk("simul.alloc_cycle", 600'(c3), 600'(c0 + 3));
    chk("simul.fill_id1", 600'(has_fill(c0 + 3, 32'h4040)), 600'(1));
    chk("simul.issue_id2", 600'(has_issue(c0 + 3, 4'd2, 32'h4080)), 600'(1));
    chk("simul.new_entry0", 600'(has_issue(c0 + 4, 4'd0, 32'h40C0)), 600'(1));

    // Response with no waiting entry is dropped.
    nf = fill_log.size();
    inj_id = 4'd3;
    inj = 1'b1;
    begin : wait_inj
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (rsp_pkt.valid) begin
          chk("badid.no_fill", 600'(fill_valid), 600'(0));
          disable wait_inj;
        end
      end
      timeout("badid.rsp");
    end
    step();
    step();
    chk("badid.fill_count", 600'(fill_log.size()), 600'(nf));

    // Reset with two reads outstanding; late responses are ignored.
    dly = 20;
    issue_log.delete(); fill_log.delete();
    alloc(MEM_OP_READ, 32'h5000, '0, c0, s);
    alloc(MEM_OP_READ, 32'h5040, '0, c1, s);
    noalloc();
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst.idle", 600'(idle), 600'(1));
    chk("rst.req_pkt", 600'(req_pkt), 600'(0));
    step();
    drain();
    chk("rst.late_rsp_ignored", 600'(fill_log.size()), 600'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
